// File: rtl/clink_pkg.sv
// Shared Camera Link Base definitions: clock-lane word, framer states and the
// 24-bit pixel to 4x7-bit lane mapping used by both the transmit and receive sides.
package clink_pkg;

  localparam logic [6:0] CLK_PATTERN = 7'b1100011;

  typedef enum logic [2:0] {IDLE, VBLANK, LINE, HBLANK, FRAME_END} tx_state_t;

  typedef struct packed {
    logic [6:0] x0;
    logic [6:0] x1;
    logic [6:0] x2;
    logic [6:0] x3;
  } clink_word_t;

  // Lane bit 6 is serialized first; pix is {C, B, A}.
  function automatic clink_word_t pack_base(input logic [23:0] pix, input logic lval,
                                            input logic fval, input logic dval);
    clink_word_t w;
    logic [7:0] a, b, c;
    a = pix[7:0];
    b = pix[15:8];
    c = pix[23:16];
    w.x0 = {b[0], a[5:0]};
    w.x1 = {c[1:0], b[5:1]};
    w.x2 = {dval, fval, lval, c[5:2]};
    w.x3 = {1'b0, c[7:6], b[7:6], a[7:6]};
    return w;
  endfunction

endpackage

// File: rtl/clink_base_pack.sv
// Registered lane-word stage: maps pixel plus sync flags onto the four data lanes.
module clink_base_pack
  import clink_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix,
  input  logic        lval,
  input  logic        fval,
  input  logic        dval,
  output logic [6:0]  x0,
  output logic [6:0]  x1,
  output logic [6:0]  x2,
  output logic [6:0]  x3
);

  clink_word_t word_d, word_q;

  always_comb word_d = pack_base(pix, lval, fval, dval);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign x0 = word_q.x0;
  assign x1 = word_q.x1;
  assign x2 = word_q.x2;
  assign x3 = word_q.x3;

endmodule

// File: rtl/clink_base_tx_framer.sv
// Camera Link Base transmit framer: frame/line/blanking FSM feeding the lane packer.
module clink_base_tx_framer
  import clink_pkg::*;
#(
  parameter int unsigned DIM_W = 12
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             enable,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [DIM_W-1:0] cfg_hblank,
  input  logic [DIM_W-1:0] cfg_vblank,
  input  logic [23:0]      s_pix_data,
  input  logic             s_pix_valid,
  output logic             s_pix_ready,
  output logic [6:0]       lane_clk,
  output logic [6:0]       lane_x0,
  output logic [6:0]       lane_x1,
  output logic [6:0]       lane_x2,
  output logic [6:0]       lane_x3,
  output logic             frame_busy,
  output logic [15:0]      underrun_cnt
);

  tx_state_t        state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d, cnt_q, cnt_d;
  logic [DIM_W-1:0] width_last_q, width_last_d, height_last_q, height_last_d;
  logic [DIM_W-1:0] hblank_last_q, hblank_last_d, vblank_last_q, vblank_last_d;
  logic             ready_q, busy_q;
  logic [15:0]      underrun_q, underrun_d;
  logic             lval, fval, dval, load_cfg;
  logic [23:0]      pix_gated;

  // A zero config field behaves like 1.
  function automatic logic [DIM_W-1:0] last_of(input logic [DIM_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    width_last_d  = width_last_q;
    height_last_d = height_last_q;
    hblank_last_d = hblank_last_q;
    vblank_last_d = vblank_last_q;
    lval          = 1'b0;
    fval          = 1'b0;
    dval          = 1'b0;
    load_cfg      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = VBLANK;
          load_cfg = 1'b1;
        end
      end
      VBLANK: begin
        if (cnt_q == vblank_last_q) begin
          state_d = LINE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LINE: begin
        fval = 1'b1;
        lval = 1'b1;
        dval = s_pix_valid;
        if (s_pix_valid) begin
          if (col_q == width_last_q) begin
            cnt_d   = '0;
            state_d = (row_q == height_last_q) ? FRAME_END : HBLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      HBLANK: begin
        fval = 1'b1;
        if (cnt_q == hblank_last_q) begin
          state_d = LINE;
          row_d   = row_q + 1'b1;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRAME_END: begin
        if (enable) begin
          state_d  = VBLANK;
          load_cfg = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Config is captured only on frame entry so it stays stable for the whole frame.
    if (load_cfg) begin
      cnt_d         = '0;
      width_last_d  = last_of(cfg_width);
      height_last_d = last_of(cfg_height);
      hblank_last_d = last_of(cfg_hblank);
      vblank_last_d = last_of(cfg_vblank);
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (state_q == LINE && !s_pix_valid && underrun_q != 16'hFFFF) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  assign pix_gated = dval ? s_pix_data : '0;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      cnt_q         <= '0;
      width_last_q  <= '0;
      height_last_q <= '0;
      hblank_last_q <= '0;
      vblank_last_q <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      width_last_q  <= width_last_d;
      height_last_q <= height_last_d;
      hblank_last_q <= hblank_last_d;
      vblank_last_q <= vblank_last_d;
      // Registered from next state so ready is high exactly while the FSM is in LINE.
      ready_q       <= (state_d == LINE);
      busy_q        <= (state_d == VBLANK) || (state_d == LINE) || (state_d == HBLANK);
      underrun_q    <= underrun_d;
    end
  end

  clink_base_pack u_pack (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .pix   (pix_gated),
    .lval  (lval),
    .fval  (fval),
    .dval  (dval),
    .x0    (lane_x0),
    .x1    (lane_x1),
    .x2    (lane_x2),
    .x3    (lane_x3)
  );

  assign lane_clk     = CLK_PATTERN;
  assign s_pix_ready  = ready_q;
  assign frame_busy   = busy_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_clink_base_tx_framer.sv
// Directed bench for clink_base_tx_framer: frame timing, lane mapping, stalls,
// enable drop and asynchronous reset, with lanes unpacked back to pixels.
module tb_clink_base_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] cfg_width, cfg_height, cfg_hblank, cfg_vblank;
  logic [23:0] s_pix_data;
  logic        s_pix_valid;
  logic        s_pix_ready;
  logic [6:0]  lane_clk, lane_x0, lane_x1, lane_x2, lane_x3;
  logic        frame_busy;
  logic [15:0] underrun_cnt;

  always #5 clk = ~clk;

  clink_base_tx_framer #(.DIM_W(12)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .enable        (enable),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .cfg_hblank    (cfg_hblank),
    .cfg_vblank    (cfg_vblank),
    .s_pix_data    (s_pix_data),
    .s_pix_valid   (s_pix_valid),
    .s_pix_ready   (s_pix_ready),
    .lane_clk      (lane_clk),
    .lane_x0       (lane_x0),
    .lane_x1       (lane_x1),
    .lane_x2       (lane_x2),
    .lane_x3       (lane_x3),
    .frame_busy    (frame_busy),
    .underrun_cnt  (underrun_cnt)
  );

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] lval_v, fval_v, dval_v, ready_v, busy_v;
  logic [6:0]  cap_x0 [32];
  logic [6:0]  cap_x1 [32];
  logic [6:0]  cap_x2 [32];
  logic [6:0]  cap_x3 [32];
  logic [23:0] got_pix [$];
  int          hs_n;
  logic        hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] unpack(input logic [6:0] x0, input logic [6:0] x1,
                                         input logic [6:0] x2, input logic [6:0] x3);
    return {x3[5:4], x2[3:0], x1[6:5], x3[3:2], x1[4:0], x0[6], x3[1:0], x0[5:0]};
  endfunction

  function automatic logic [31:0] pix_at(input int k);
    return (k < got_pix.size()) ? 32'(got_pix[k]) : 32'hFFFF_FFFF;
  endfunction

  // Bit i of each trace vector is the value sampled in cycle i after enable was raised.
  task automatic run(input int n, input logic [11:0] w, input logic [11:0] h,
                     input logic [11:0] hb, input logic [11:0] vb, input logic [23:0] base,
                     input logic [31:0] stall, input int drop_at);
    lval_v = '0; fval_v = '0; dval_v = '0; ready_v = '0; busy_v = '0;
    got_pix.delete();
    hs_n = 0;
    hs = 1'b0;
    @(posedge clk); #1;
    cfg_width = w; cfg_height = h; cfg_hblank = hb; cfg_vblank = vb;
    s_pix_data = base;
    s_pix_valid = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (hs) s_pix_data = s_pix_data + 24'd1;
      enable = (i < drop_at);
      s_pix_valid = !stall[i];
      @(negedge clk);
      lval_v[i]  = lane_x2[4];
      fval_v[i]  = lane_x2[5];
      dval_v[i]  = lane_x2[6];
      ready_v[i] = s_pix_ready;
      busy_v[i]  = frame_busy;
      cap_x0[i] = lane_x0; cap_x1[i] = lane_x1; cap_x2[i] = lane_x2; cap_x3[i] = lane_x3;
      if (lane_x2[6]) got_pix.push_back(unpack(lane_x0, lane_x1, lane_x2, lane_x3));
      hs = s_pix_ready && s_pix_valid;
      if (hs) hs_n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0;
    cfg_width = '0; cfg_height = '0; cfg_hblank = '0; cfg_vblank = '0;
    repeat (3) @(negedge clk);
    check("rst_x0", 32'(lane_x0), 32'h0);
    check("rst_x2", 32'(lane_x2), 32'h0);
    check("rst_x3", 32'(lane_x3), 32'h0);
    check("rst_clk", 32'(lane_clk), 32'h63);
    check("rst_ready", 32'(s_pix_ready), 32'h0);
    check("rst_busy", 32'(frame_busy), 32'h0);
    check("rst_underrun", 32'(underrun_cnt), 32'h0);
    rst_n = 1'b1;

    // 4x2 frame, hblank 3, vblank 5, ramp from 1
    run(24, 12'd4, 12'd2, 12'd3, 12'd5, 24'h000001, 32'h0, 2);
    check("f1_lval", lval_v, 32'h0003_C780);
    check("f1_fval", fval_v, 32'h0003_FF80);
    check("f1_dval", dval_v, 32'h0003_C780);
    check("f1_ready", ready_v, 32'h0001_E3C0);
    check("f1_busy", busy_v, 32'h0001_FFFE);
    check("f1_consumed", 32'(hs_n), 32'd8);
    check("f1_npix", 32'(got_pix.size()), 32'd8);
    for (int k = 0; k < 8; k++) check($sformatf("f1_pix%0d", k), pix_at(k), 32'(k + 1));
    check("f1_idle_x2", 32'(cap_x2[20]), 32'h0);
    check("f1_underrun", 32'(underrun_cnt), 32'h0);
    check("f1_clk", 32'(lane_clk), 32'h63);

    // Single pixel 0xC3B2A1: lane mapping
    run(5, 12'd1, 12'd1, 12'd1, 12'd1, 24'hC3B2A1, 32'h0, 2);
    check("map_x0", 32'(cap_x0[3]), 32'h21);
    check("map_x1", 32'(cap_x1[3]), 32'h79);
    check("map_x2", 32'(cap_x2[3]), 32'h70);
    check("map_x3", 32'(cap_x3[3]), 32'h3A);
    check("map_pix", pix_at(0), 32'hC3B2A1);
    check("map_fe_x2", 32'(cap_x2[4]), 32'h0);
    check("map_consumed", 32'(hs_n), 32'd1);

    // 3-cycle valid gap inside a 4-pixel line
    run(12, 12'd4, 12'd1, 12'd1, 12'd1, 24'h5A5A5A, 32'h0000_0070, 2);
    check("st_lval", lval_v, 32'h0000_03F8);
    check("st_dval", dval_v, 32'h0000_0318);
    check("st_ready", ready_v, 32'h0000_01FC);
    check("st_consumed", 32'(hs_n), 32'd4);
    check("st_gap_pix", 32'(unpack(cap_x0[5], cap_x1[5], cap_x2[5], cap_x3[5])), 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("st_pix%0d", k), pix_at(k), 32'(24'h5A5A5A + k));
    check("st_underrun", 32'(underrun_cnt), 32'd3);

    // Enable dropped during row 0 of a 2x2 frame
    run(12, 12'd2, 12'd2, 12'd1, 12'd2, 24'h000100, 32'h0, 3);
    check("en_busy", busy_v, 32'h0000_00FE);
    check("en_ready", ready_v, 32'h0000_00D8);
    check("en_consumed", 32'(hs_n), 32'd4);
    check("en_idle_x2", 32'(cap_x2[10]), 32'h0);
    check("en_busy_end", 32'(frame_busy), 32'h0);

    // Enable held across one frame boundary: two back-to-back 1x1 frames
    run(10, 12'd1, 12'd1, 12'd1, 12'd1, 24'h000200, 32'h0, 5);
    check("b2b_ready", ready_v, 32'h0000_0024);
    check("b2b_busy", busy_v, 32'h0000_0036);
    check("b2b_consumed", 32'(hs_n), 32'd2);

    // Async reset mid-line, then a fresh frame
    run(3, 12'd4, 12'd1, 12'd1, 12'd1, 24'h777777, 32'h0, 99);
    check("ar_inline", 32'(lane_x2[4]), 32'h1);
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("ar_x0", 32'(lane_x0), 32'h0);
    check("ar_x2", 32'(lane_x2), 32'h0);
    check("ar_ready", 32'(s_pix_ready), 32'h0);
    check("ar_busy", 32'(frame_busy), 32'h0);
    check("ar_underrun", 32'(underrun_cnt), 32'h0);
    check("ar_clk", 32'(lane_clk), 32'h63);
    @(negedge clk);
    rst_n = 1'b1;
    run(6, 12'd2, 12'd1, 12'd1, 12'd1, 24'h000010, 32'h0, 2);
    check("ar_new_ready", ready_v, 32'h0000_000C);
    check("ar_new_consumed", 32'(hs_n), 32'd2);
    check("ar_new_pix0", pix_at(0), 32'h10);
    check("ar_new_pix1", pix_at(1), 32'h11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
